// File: rtl/tt_um_ha.sv
// tt_um_ha: Tiny Tapeout tile built from half-adder cells.
// A 4-bit bitwise half-add, ripple adder and incrementer share the operands.
// A saturating carry-event counter sits beside them. All results are registered.

// Single half-adder cell: the only arithmetic primitive in the tile.
module tt_um_ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// Full adder composed of two half-adders plus an OR on the carries.
module tt_um_ha_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1, c1, c2;

    tt_um_ha_cell u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
    tt_um_ha_cell u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

module tt_um_ha (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic [W-1:0]     op_a, op_b;
    logic [1:0]       mode;
    logic             clr;

    // Per-bit half-add outputs (mode 00)
    logic [W-1:0]     hs, hc;
    // Ripple adder sums and carries (mode 01)
    logic [W-1:0]     rs, rc;
    // Incrementer sums and carry chain (mode 10); ic[0] is the carry-in
    logic [W-1:0]     is;
    logic [W:0]       ic;

    logic [7:0]       res_d, res_q;
    logic             flag_d, flag_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             unused_sink;

    assign op_a = ui_in[3:0];
    assign op_b = ui_in[7:4];
    assign mode = uio_in[1:0];
    assign clr  = uio_in[2];
    assign ic[0] = op_b[0];

    // Three parallel datapaths, one cell column per operand bit
    for (genvar i = 0; i < W; i++) begin : g_bit
        tt_um_ha_cell u_hadd (.a(op_a[i]), .b(op_b[i]), .s(hs[i]), .c(hc[i]));
        tt_um_ha_cell u_inc  (.a(op_a[i]), .b(ic[i]),   .s(is[i]), .c(ic[i+1]));
        if (i == 0) begin : g_lsb
            tt_um_ha_cell u_add (.a(op_a[i]), .b(op_b[i]), .s(rs[i]), .c(rc[i]));
        end else begin : g_fa
            tt_um_ha_fa u_add (.a(op_a[i]), .b(op_b[i]), .ci(rc[i-1]),
                               .s(rs[i]), .co(rc[i]));
        end
    end

    // Result/flag select and next counter value
    always_comb begin
        res_d  = 8'h00;
        flag_d = 1'b0;
        unique case (mode)
            2'b00: begin
                res_d  = {hc, hs};
                flag_d = |hc;
            end
            2'b01: begin
                res_d  = {3'b000, rc[W-1], rs};
                flag_d = rc[W-1];
            end
            2'b10: begin
                res_d  = {3'b000, ic[W], is};
                flag_d = ic[W];
            end
            default: begin
                // Readout shows the pre-update counter, so a same-cycle
                // clear still reports the old value.
                res_d  = cnt_q;
                flag_d = 1'b0;
            end
        endcase

        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (flag_d && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // State registers; everything holds while the tile is deselected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= 8'h00;
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else if (ena) begin
            res_q  <= res_d;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign uo_out  = res_q;
    assign uio_out = {cnt_q[3:0], 4'b0000};
    assign uio_oe  = 8'hF0;

    // The flag register and upper uio inputs are not routed to any pin.
    assign unused_sink = &{1'b0, uio_in[7:3], flag_q, cnt_q[CNT_W-1:4]};
endmodule

// File: tb/tb_tt_um_ha.sv
// Directed scoreboard bench for tt_um_ha.
module tb_tt_um_ha;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_cnt;
    logic [7:0] m_res;

    tt_um_ha dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, got, want);
        end
    endtask

    // Drive one cycle of stimulus, push the model result, then compare after the edge
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [1:0] md,
                        input logic cl, input logic en);
        logic [7:0] r;
        logic       f;
        logic [7:0] got;
        @(negedge clk);
        ui_in  = {b, a};
        uio_in = {5'b10101, cl, md};
        ena    = en;
        case (md)
            2'd0: begin r = {a & b, a ^ b}; f = |(a & b); end
            2'd1: begin r = 8'(a) + 8'(b); f = r[4]; end
            2'd2: begin r = 8'(a) + 8'(b[0]); f = r[4]; end
            default: begin r = m_cnt; f = 1'b0; end
        endcase
        if (en) begin
            m_res = r;
            if (cl) m_cnt = 8'd0;
            else if (f && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        end
        exp_q.push_back(m_res);
        @(posedge clk);
        #1;
        total++;
        assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            check("uo_out", uo_out, got);
        end
        check("uio_out", uio_out, {m_cnt[3:0], 4'h0});
        check("uio_oe", uio_oe, 8'hF0);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'hA5;
        uio_in = 8'h03;
        m_cnt  = 8'd0;
        m_res  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b1;

        step(4'h0, 4'h0, 2'd0, 1'b0, 1'b1);   // idle -> 00
        step(4'hA, 4'h6, 2'd0, 1'b0, 1'b1);   // half-add -> 2C, cnt 1
        check("halfadd_const", uo_out, 8'h2C);
        check("halfadd_cnt", uio_out, 8'h10);
        step(4'hF, 4'hF, 2'd1, 1'b0, 1'b1);   // add -> 1E
        check("add_ff_const", uo_out, 8'h1E);
        step(4'h3, 4'h4, 2'd1, 1'b0, 1'b1);   // add -> 07, no count
        check("add_34_const", uo_out, 8'h07);
        step(4'hF, 4'h1, 2'd2, 1'b0, 1'b1);   // inc -> 10
        check("inc_f1_const", uo_out, 8'h10);
        step(4'h5, 4'hE, 2'd2, 1'b0, 1'b1);   // inc, B[0]=0 -> 05
        check("inc_5e_const", uo_out, 8'h05);
        step(4'h9, 4'h7, 2'd0, 1'b0, 1'b1);
        step(4'h8, 4'h9, 2'd1, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) step(4'hF, 4'hF, 2'd1, 1'b0, 1'b1);
        step(4'h0, 4'h0, 2'd3, 1'b0, 1'b1);   // saturated readout
        check("sat_const", uo_out, 8'hFF);
        step(4'h0, 4'h0, 2'd3, 1'b1, 1'b1);   // clear: readout still pre-clear
        check("clr_preval", uo_out, 8'hFF);
        step(4'h0, 4'h0, 2'd3, 1'b0, 1'b1);   // post-clear readout
        check("clr_post", uo_out, 8'h00);

        step(4'hF, 4'hF, 2'd0, 1'b0, 1'b1);   // F0, cnt 1
        step(4'h3, 4'h5, 2'd1, 1'b0, 1'b0);   // deselected: hold
        step(4'hF, 4'hF, 2'd1, 1'b1, 1'b0);
        check("ena_hold", uo_out, 8'hF0);
        step(4'h6, 4'h2, 2'd3, 1'b0, 1'b1);   // readout counter -> 01
        for (int i = 0; i < 20; i++)
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 3) != 0));

        step(4'hC, 4'hC, 2'd0, 1'b0, 1'b1);   // non-zero result before async reset
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_uo", uo_out, 8'h00);
        check("async_rst_uio", uio_out, 8'h00);
        check("async_rst_oe", uio_oe, 8'hF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tt_um_ha.md
Name: tt_um_ha

Overview:
Tiny Tapeout user tile built around half-adder cells. Two 4-bit operands on the dedicated inputs feed a selectable arithmetic function: bitwise half-add, ripple-carry add, or half-adder incrementer. A carry-event counter sits alongside the datapath. All results are registered and driven on the dedicated outputs; part of the counter is also exposed on the bidirectional pins.

Parameters:
CNT_W, 8, width of the saturating carry-event counter (fixed at 8 for the tile; uo_out shows it in full).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
ena  input  1  tile enable; high when the design is selected.
ui_in  input  8  [3:0] operand A, [7:4] operand B.
uo_out  output  8  registered result (see Behaviour).
uio_in  input  8  [1:0] mode, [2] counter clear, [7:3] ignored.
uio_out  output  8  [7:4] counter[3:0], [3:0] constant 0.
uio_oe  output  8  constant 8'hF0 (uio[7:4] outputs, uio[3:0] inputs).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low on rst_n.
- While rst_n = 0: result register = 0, flag register = 0, counter = 0. So uo_out = 0 and uio_out = 0. uio_oe = 8'hF0 at all times, including during reset.
- Combinational next-result from A = ui_in[3:0], B = ui_in[7:4], mode = uio_in[1:0]:
  - mode 00 (bitwise half-add): res[3:0] = A ^ B; res[7:4] = A & B; flag = |(A & B).
  - mode 01 (ripple add): build from half-adder cells (full adder = two HAs plus OR). res[4:0] = A + B, 5-bit unsigned, no truncation; res[7:5] = 0; flag = res[4].
  - mode 10 (incrementer): chain of 4 half-adders, carry-in = B[0]. res[4:0] = A + B[0]; res[7:5] = 0; flag = res[4]. B[3:1] are ignored.
  - mode 11 (readout): res = counter value sampled at this edge (pre-update); flag = 0.
- Registering:
  - On each rising clk with ena = 1: result register <= res and flag register <= flag.
  - With ena = 0: result, flag and counter all hold.
  - uo_out = result register, giving one-cycle latency from inputs to output.
- Counter:
  - On a rising clk with ena = 1: if uio_in[2] = 1, counter <= 0. Otherwise, if flag (the combinational flag of the current cycle) = 1, counter <= counter + 1, saturating at 255 (no wrap).
  - Clear has priority over increment.
  - A mode-11 readout in the same cycle as a clear shows the pre-clear value.
- uio_out[7:4] = counter[3:0], reflecting the counter register directly; no extra latency beyond the counter register itself. uio_out[3:0] = 0.
- Boundary cases:
  - A = B = 4'hF in mode 01 gives 0x1E with flag 1.
  - A = 4'hF, B[0] = 1 in mode 10 gives 0x10.
  - Mode changes take effect at the next edge; there is no pipeline flush.
  - Asserting rst_n low mid-operation clears all state immediately, without waiting for a clock edge.
- No X propagation: all outputs are defined for any input combination.

Test Plan:
- Reset: hold rst_n = 0 with arbitrary inputs -> uo_out = 0x00, uio_out = 0x00, uio_oe = 0xF0. Release and wait one idle clock with A = B = 0, mode 00 -> uo_out = 0x00.
- Half-add, mode 00: A = 4'b1010, B = 4'b0110, ena = 1, one clock -> uo_out = 0x2C (sum 1100, carry 0010). Counter increments to 1, so uio_out = 0x10.
- Adder, mode 01: A = 0xF, B = 0xF -> uo_out = 0x1E after one clock. A = 3, B = 4 -> uo_out = 0x07 and the counter does not increment.
- Incrementer, mode 10: A = 0xF, ui_in[7:4] = 0x1 -> uo_out = 0x10. A = 5, B = 0xE (B[0] = 0) -> uo_out = 0x05.
- Counter: 300 clocks with mode 01, A = B = 0xF, then mode 11 -> uo_out = 0xFF (saturated). Pulse uio_in[2] for one clock -> the next mode-11 readout is 0x00.
- Enable/reset: set ena = 0 and change the inputs -> uo_out and counter unchanged. Drive rst_n low between clock edges -> uo_out = 0 immediately.
